// File: rtl/led_pkg.sv
// Shared types and helpers for the LED clock-divider slice: the period meter
// and the divider both size their counters from LED_CNT_W.
package led_pkg;

  localparam int LED_CNT_W = 30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } meter_state_t;

  // Priority encoder: index of the highest set bit, 0 for a zero input.
  function automatic logic [4:0] floor_log2(input logic [LED_CNT_W-1:0] value);
    floor_log2 = '0;
    for (int i = 0; i < LED_CNT_W; i++) begin
      if (value[i]) floor_log2 = 5'(i);
    end
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input followed by a one-cycle
// rising-edge pulse. Also used for the board's button inputs.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delayed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      delayed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], d};
      delayed_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~delayed_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the period of a (possibly asynchronous) divided clock in clk_in
// cycles, flagging changes and reporting a timeout when edges stop arriving.
//
// Output protocol: period_valid is a one-cycle pulse with no back-pressure;
// period, period_log2 and period_changed are valid in that cycle, and period
// and period_log2 hold until the next pulse. timeout is a level.
module clock_period_meter
  import led_pkg::*;
#(
  parameter int               CNT_W       = LED_CNT_W,
  parameter int               SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] MAX_PERIOD  = CNT_W'(32'h2000_0000)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             period_changed,
  output logic [4:0]       period_log2,
  output logic             timeout,
  output meter_state_t     state_dbg
);

  logic sig_level;
  logic rise;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk_in),
    .rst  (reset),
    .d    (sig_in),
    .level(sig_level),
    .rise (rise)
  );

  meter_state_t     state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] period_q,  period_d;
  logic [4:0]       log2_q,    log2_d;
  logic             valid_q,   valid_d;
  logic             changed_q, changed_d;
  logic             timeout_q, timeout_d;
  logic             have_prev_q, have_prev_d;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      log2_q      <= '0;
      valid_q     <= 1'b0;
      changed_q   <= 1'b0;
      timeout_q   <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      log2_q      <= log2_d;
      valid_q     <= valid_d;
      changed_q   <= changed_d;
      timeout_q   <= timeout_d;
      have_prev_q <= have_prev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    log2_d      = log2_q;
    valid_d     = 1'b0;
    changed_d   = 1'b0;
    timeout_d   = timeout_q;
    have_prev_d = have_prev_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
        end
      end
      MEASURE: begin
        // An edge landing on the MAX_PERIOD cycle still counts as a measurement.
        if (rise) begin
          period_d    = cnt_q;
          log2_d      = floor_log2(LED_CNT_W'(cnt_q));
          valid_d     = 1'b1;
          changed_d   = !have_prev_q || (cnt_q != period_q);
          cnt_d       = CNT_W'(1);
          have_prev_d = 1'b1;
        end else if (cnt_q == MAX_PERIOD) begin
          state_d     = TIMEOUT;
          timeout_d   = 1'b1;
          have_prev_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TIMEOUT: begin
        if (rise) begin
          state_d   = MEASURE;
          cnt_d     = CNT_W'(1);
          timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign period         = period_q;
  assign period_valid   = valid_q;
  assign period_changed = changed_q;
  assign period_log2    = log2_q;
  assign timeout        = timeout_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomised and directed bench for clock_period_meter: the reference model
// works on gaps between driven rising edges and feeds a scoreboard queue.
module tb_clock_period_meter;
  import led_pkg::*;

  localparam int          CNT_W = 30;
  localparam int          MAXP  = 64;
  localparam int          EXP_W = CNT_W + 5 + 1;

  logic             clk_in = 1'b0;
  logic             reset  = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             period_changed;
  logic [4:0]       period_log2;
  logic             timeout;
  meter_state_t     state_dbg;

  clock_period_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2),
    .MAX_PERIOD (CNT_W'(MAXP))
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .sig_in        (sig_in),
    .period        (period),
    .period_valid  (period_valid),
    .period_changed(period_changed),
    .period_log2   (period_log2),
    .timeout       (timeout),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic             tmo_q[$];
  int               checks = 0;
  int               errors = 0;

  // Reference model: measures gaps between driven rising edges of sig_in.
  int  t_now     = 0;
  int  last_t    = 0;
  bit  in_meas   = 0;
  bit  have_prev = 0;
  int  last_per  = 0;
  bit  prev_s    = 0;

  function automatic int ref_log2(input int v);
    int l;
    l = 0;
    while (v > 1) begin
      v = v / 2;
      l++;
    end
    return l;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    in_meas   = 0;
    have_prev = 0;
    last_per  = 0;
    prev_s    = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic s);
    bit rise_now;
    int gap;
    rise_now = s && !prev_s;
    prev_s   = s;
    sig_in   = s;
    if (rise_now) begin
      if (in_meas) begin
        gap = t_now - last_t;
        exp_q.push_back({(!have_prev || gap != last_per), 5'(ref_log2(gap)), CNT_W'(gap)});
        have_prev = 1;
        last_per  = gap;
      end
      in_meas = 1;
      last_t  = t_now;
    end else if (in_meas && (t_now - last_t) == MAXP) begin
      tmo_q.push_back(1'b1);
      in_meas   = 0;
      have_prev = 0;
    end
    t_now++;
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_train(input int n, input int per, input int hw);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < per; j++) tick(j < hw);
    end
  endtask

  task automatic hold(input logic s, input int n);
    for (int i = 0; i < n; i++) tick(s);
  endtask

  // ---------------- monitor ----------------
  logic prev_tmo = 1'b0;
  always @(negedge clk_in) begin
    logic [EXP_W-1:0] e;
    if (reset) begin
      prev_tmo <= 1'b0;
    end else begin
      if (period_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("period", period, e[CNT_W-1:0]);
          check("period_log2", period_log2, e[CNT_W+4:CNT_W]);
          check("period_changed", period_changed, e[EXP_W-1]);
          check("timeout_at_valid", timeout, 0);
        end
      end
      if (timeout && !prev_tmo) begin
        if (tmo_q.size() == 0) check("unexpected_timeout", 1, 0);
        else check("timeout_rise", timeout, tmo_q.pop_front());
      end
      prev_tmo <= timeout;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int per, hw;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_period", period, 0);
    check("rst_valid", period_valid, 0);
    check("rst_log2", period_log2, 0);
    check("rst_timeout", timeout, 0);
    reset = 1'b0;
    hold(0, 4);

    // Steady 16, switch to 8, toggling, then timeout and recovery.
    pulse_train(4, 16, 1);
    pulse_train(1, 16, 1);
    pulse_train(3, 8, 1);
    pulse_train(10, 2, 1);
    pulse_train(3, 10, 1);
    hold(0, 80);
    check("timeout_level", timeout, 1);
    tick(1);
    hold(0, 9);
    tick(1);
    hold(0, 9);
    // Gaps exactly at the limit.
    pulse_train(4, MAXP, 1);
    pulse_train(2, MAXP + 1, 1);

    // Random periods and duty cycles, including gaps past the limit.
    for (int i = 0; i < 60; i++) begin
      per = $urandom_range(2, MAXP + 8);
      hw  = $urandom_range(1, per - 1);
      pulse_train($urandom_range(1, 3), per, hw);
    end

    // Mid-interval asynchronous reset, release with sig_in high.
    pulse_train(3, 16, 1);
    hold(0, 8);
    #2 reset = 1'b1;
    #1;
    check("async_period", period, 0);
    check("async_log2", period_log2, 0);
    check("async_valid", period_valid, 0);
    check("async_changed", period_changed, 0);
    check("async_timeout", timeout, 0);
    model_reset();
    sig_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    reset = 1'b0;
    tick(1);
    hold(0, 15);
    pulse_train(2, 16, 1);
    hold(0, 10);

    check("exp_q_drained", exp_q.size(), 0);
    check("tmo_q_drained", tmo_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case stimulus stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
